// File: rtl/mu0_core_param_if.sv
// rtl/mu0_core_param_if.sv - MU0 memory bus: Rd/Wr request held until Ack
interface mu0_core_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] Dout;
   logic [DATA_W-1:0] Din;
   logic              Rd;
   logic              Wr;
   logic              Ack;

   modport master (output Address, Dout, Rd, Wr, input Din, Ack);
   modport slave  (input Address, Dout, Rd, Wr, output Din, Ack);
endinterface

// File: rtl/mu0_core_param.sv
// rtl/mu0_core_param.sv - parameterised MU0 accumulator core (FETCH/EXEC/HALT)
module mu0_core_param #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              Clk,
   input  logic              Reset,
   mu0_core_param_if.master  bus,
   output logic [3:0]        F,
   output logic [ADDR_W-1:0] PC,
   output logic [DATA_W-1:0] Acc,
   output logic              N,
   output logic              Z,
   output logic              Halted,
   output logic              Illegal
);
   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

   localparam logic [3:0] OP_LDA = 4'd0;
   localparam logic [3:0] OP_STA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_JMP = 4'd4;
   localparam logic [3:0] OP_JGE = 4'd5;
   localparam logic [3:0] OP_JNE = 4'd6;
   localparam logic [3:0] OP_STP = 4'd7;

   state_t            state_q, state_nxt;
   logic [DATA_W-1:0] ir_q, ir_nxt;
   logic [DATA_W-1:0] acc_q, acc_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic              illegal_q, illegal_nxt;
   logic              rd, wr;
   logic [3:0]        op;
   logic [ADDR_W-1:0] s;
   logic              mem_op;

   assign op     = ir_q[DATA_W-1 -: 4];
   assign s      = ir_q[ADDR_W-1:0];
   assign mem_op = (state_q == EXEC) &&
                   (op == OP_LDA || op == OP_STA || op == OP_ADD || op == OP_SUB);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= FETCH;
         ir_q      <= '0;
         acc_q     <= '0;
         pc_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         ir_q      <= ir_nxt;
         acc_q     <= acc_nxt;
         pc_q      <= pc_nxt;
         illegal_q <= illegal_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_q;
      ir_nxt      = ir_q;
      acc_nxt     = acc_q;
      pc_nxt      = pc_q;
      illegal_nxt = illegal_q;
      rd          = 1'b0;
      wr          = 1'b0;
      case (state_q)
         FETCH: begin
            rd = 1'b1;
            if (bus.Ack) begin
               ir_nxt    = bus.Din;
               pc_nxt    = pc_q + ADDR_W'(1);
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            case (op)
               OP_LDA, OP_ADD, OP_SUB: begin
                  rd = 1'b1;
                  if (bus.Ack) begin
                     if (op == OP_LDA)      acc_nxt = bus.Din;
                     else if (op == OP_ADD) acc_nxt = acc_q + bus.Din;
                     else                   acc_nxt = acc_q - bus.Din;
                     state_nxt = FETCH;
                  end
               end
               OP_STA: begin
                  wr = 1'b1;
                  if (bus.Ack) state_nxt = FETCH;
               end
               OP_JMP: begin
                  pc_nxt    = s;
                  state_nxt = FETCH;
               end
               OP_JGE: begin
                  if (!acc_q[DATA_W-1]) pc_nxt = s;
                  state_nxt = FETCH;
               end
               OP_JNE: begin
                  if (acc_q != '0) pc_nxt = s;
                  state_nxt = FETCH;
               end
               OP_STP: state_nxt = HALT;
               default: begin
                  illegal_nxt = 1'b1;
                  state_nxt   = HALT;
               end
            endcase
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // Requests are gated by Reset so an in-flight access drops without waiting for a clock.
   assign bus.Rd      = rd & ~Reset;
   assign bus.Wr      = wr & ~Reset;
   assign bus.Address = mem_op ? s : pc_q;
   assign bus.Dout    = acc_q;

   assign F       = op;
   assign PC      = pc_q;
   assign Acc     = acc_q;
   assign N       = acc_q[DATA_W-1];
   assign Z       = (acc_q == '0);
   assign Halted  = (state_q == HALT);
   assign Illegal = illegal_q;
endmodule

// File: tb/tb_mu0_core_param.sv
// tb/tb_mu0_core_param.sv - mu0_core_param against an instruction-level reference model
module tb_mu0_core_param;
   localparam int DW    = 16;
   localparam int AW    = 12;
   localparam int MEM_N = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mu0_core_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   logic [3:0]    f;
   logic [AW-1:0] pc;
   logic [DW-1:0] acc;
   logic          n, z, halted, illegal;

   mu0_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .Clk(clk), .Reset(rst), .bus(bus), .F(f), .PC(pc), .Acc(acc),
      .N(n), .Z(z), .Halted(halted), .Illegal(illegal)
   );

   mu0_core_param_if #(.DATA_W(8), .ADDR_W(4)) bus8 ();
   logic [3:0] f8;
   logic [3:0] pc8;
   logic [7:0] acc8;
   logic       n8, z8, halted8, illegal8;

   mu0_core_param #(.DATA_W(8), .ADDR_W(4)) dut8 (
      .Clk(clk), .Reset(rst), .bus(bus8), .F(f8), .PC(pc8), .Acc(acc8),
      .N(n8), .Z(z8), .Halted(halted8), .Illegal(illegal8)
   );

   logic [DW-1:0] mem     [MEM_N];
   logic [DW-1:0] ref_mem [MEM_N];
   logic [7:0]    mem8    [16];

   int            n_cmp = 0;
   int            n_fail = 0;
   int            delay = 0;
   int            wait_cnt = 0;
   bit            spurious = 1'b0;
   bit            ack_hold = 1'b0;
   logic [AW-1:0] hold_addr;
   logic          hold_rd, hold_wr;

   logic [AW-1:0] m_pc;
   logic [DW-1:0] m_acc;
   bit            m_halt, m_ill;
   int            m_cyc;

   // One clock of the memory: answer the request visible now, then advance to the next falling edge.
   task automatic step();
      n_cmp++;
      if (bus.Rd === 1'b1 && bus.Wr === 1'b1) begin
         n_fail++;
         $display("FAIL rd_wr_exclusive: Rd=%b Wr=%b, required not both 1 at %0t", bus.Rd, bus.Wr, $time);
      end
      if (bus.Rd || bus.Wr) begin
         if (wait_cnt == 0) begin
            hold_addr = bus.Address;
            hold_rd   = bus.Rd;
            hold_wr   = bus.Wr;
         end else begin
            n_cmp++;
            if ({bus.Address, bus.Rd, bus.Wr} !== {hold_addr, hold_rd, hold_wr}) begin
               n_fail++;
               $display("FAIL request_stable: addr=%h rd=%b wr=%b, required addr=%h rd=%b wr=%b",
                        bus.Address, bus.Rd, bus.Wr, hold_addr, hold_rd, hold_wr);
            end
         end
         if (!ack_hold && wait_cnt >= delay) begin
            bus.Ack = 1'b1;
            if (bus.Rd) bus.Din = mem[bus.Address];
            else        mem[bus.Address] = bus.Dout;
            wait_cnt = 0;
         end else begin
            bus.Ack = 1'b0;
            bus.Din = DW'($urandom);
            wait_cnt++;
         end
      end else begin
         bus.Ack  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.Din  = DW'($urandom);
         wait_cnt = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step8();
      if (bus8.Rd) begin
         bus8.Ack = 1'b1;
         bus8.Din = mem8[bus8.Address];
      end else if (bus8.Wr) begin
         bus8.Ack = 1'b1;
         mem8[bus8.Address] = bus8.Dout;
      end else begin
         bus8.Ack = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      bus.Ack  = 1'b0;
      bus8.Ack = 1'b0;
      wait_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic clear_mem();
      for (int a = 0; a < MEM_N; a++) mem[a] = '0;
   endtask

   // Instruction-at-a-time interpreter; cycle cost is 1+d per memory access and 1 otherwise.
   task automatic run_model(input int d, input int k);
      logic [DW-1:0] instr;
      logic [AW-1:0] s;
      m_pc = '0; m_acc = '0; m_halt = 1'b0; m_ill = 1'b0; m_cyc = 0;
      for (int i = 0; i < k && !m_halt; i++) begin
         instr = ref_mem[m_pc];
         m_pc  = m_pc + AW'(1);
         m_cyc += 1 + d;
         s = instr[AW-1:0];
         case (instr[DW-1:DW-4])
            4'd0: begin m_acc = ref_mem[s];         m_cyc += 1 + d; end
            4'd1: begin ref_mem[s] = m_acc;         m_cyc += 1 + d; end
            4'd2: begin m_acc = m_acc + ref_mem[s]; m_cyc += 1 + d; end
            4'd3: begin m_acc = m_acc - ref_mem[s]; m_cyc += 1 + d; end
            4'd4: begin m_pc = s;                   m_cyc += 1; end
            4'd5: begin if (!m_acc[DW-1]) m_pc = s; m_cyc += 1; end
            4'd6: begin if (m_acc != 0) m_pc = s;   m_cyc += 1; end
            4'd7: begin m_halt = 1'b1;              m_cyc += 1; end
            default: begin m_halt = 1'b1; m_ill = 1'b1; m_cyc += 1; end
         endcase
      end
   endtask

   task automatic execute_and_check(input int d, input int k, input string name);
      int errs;
      for (int a = 0; a < MEM_N; a++) ref_mem[a] = mem[a];
      run_model(d, k);
      delay = d;
      do_reset();
      repeat (m_cyc) step();
      n_cmp++; if (pc !== m_pc) begin n_fail++; $display("FAIL %s pc: got %h, required %h", name, pc, m_pc); end
      n_cmp++; if (acc !== m_acc) begin n_fail++; $display("FAIL %s acc: got %h, required %h", name, acc, m_acc); end
      n_cmp++; if (halted !== m_halt) begin n_fail++; $display("FAIL %s halted: got %b, required %b", name, halted, m_halt); end
      n_cmp++; if (illegal !== m_ill) begin n_fail++; $display("FAIL %s illegal: got %b, required %b", name, illegal, m_ill); end
      n_cmp++; if (n !== m_acc[DW-1] || z !== (m_acc == 0)) begin n_fail++; $display("FAIL %s flags: got N=%b Z=%b for acc %h", name, n, z, m_acc); end
      errs = 0;
      for (int a = 0; a < MEM_N; a++) if (mem[a] !== ref_mem[a]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL %s mem: %0d words differ, required 0", name, errs); end
      if (m_halt) begin
         repeat (3) begin
            step();
            n_cmp++;
            if (bus.Rd !== 1'b0 || bus.Wr !== 1'b0 || pc !== m_pc || acc !== m_acc) begin
               n_fail++;
               $display("FAIL %s halt_hold: rd=%b wr=%b pc=%h acc=%h, required 0 0 %h %h", name, bus.Rd, bus.Wr, pc, acc, m_pc, m_acc);
            end
         end
      end
   endtask

   task automatic load_basic();
      clear_mem();
      mem[0] = 16'h0005; mem[1] = 16'h2006; mem[2] = 16'h1007; mem[3] = 16'h7000;
      mem[5] = 16'h0003; mem[6] = 16'hFFFF;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.Rd !== 1'b0 || bus.Wr !== 1'b0) begin n_fail++; $display("FAIL reset_req: rd=%b wr=%b, required 0 0", bus.Rd, bus.Wr); end
      n_cmp++; if (pc !== '0 || acc !== '0 || f !== 4'd0) begin n_fail++; $display("FAIL reset_regs: pc=%h acc=%h f=%h, required 0", pc, acc, f); end
      n_cmp++; if (halted !== 1'b0 || illegal !== 1'b0 || z !== 1'b1) begin n_fail++; $display("FAIL reset_status: halted=%b illegal=%b z=%b, required 0 0 1", halted, illegal, z); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.Rd !== 1'b1 || bus.Address !== '0) begin n_fail++; $display("FAIL reset_first_fetch: rd=%b addr=%h, required 1 000", bus.Rd, bus.Address); end
   endtask

   task automatic test_basic();
      load_basic();
      spurious = 1'b0;
      execute_and_check(0, 20, "basic_model");
      load_basic();
      delay = 0;
      do_reset();
      repeat (7) step();
      n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL basic_early_halt: halted=%b after 7 cycles, required 0", halted); end
      step();
      n_cmp++; if (halted !== 1'b1 || pc !== 12'h004) begin n_fail++; $display("FAIL basic_halt: halted=%b pc=%h, required 1 004", halted, pc); end
      n_cmp++; if (acc !== 16'h0002 || mem[7] !== 16'h0002) begin n_fail++; $display("FAIL basic_result: acc=%h mem7=%h, required 0002 0002", acc, mem[7]); end
   endtask

   task automatic test_wait_states();
      load_basic();
      spurious = 1'b0;
      delay = 3;
      do_reset();
      repeat (28) step();
      n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL wait_early_halt: halted=%b after 28 cycles, required 0", halted); end
      step();
      n_cmp++; if (halted !== 1'b1 || pc !== 12'h004) begin n_fail++; $display("FAIL wait_halt: halted=%b pc=%h, required 1 004", halted, pc); end
      n_cmp++; if (acc !== 16'h0002 || mem[7] !== 16'h0002) begin n_fail++; $display("FAIL wait_result: acc=%h mem7=%h, required 0002 0002", acc, mem[7]); end
   endtask

   task automatic test_jumps();
      clear_mem();
      mem[0] = 16'h000A; mem[1] = 16'h5020; mem[2] = 16'h000B; mem[3] = 16'h6020;
      mem[12'h020] = 16'h000C; mem[12'h021] = 16'h6030; mem[12'h022] = 16'h4FFF;
      mem[12'hFFF] = 16'h7000;
      mem[10] = 16'h8000; mem[11] = 16'h0001; mem[12] = 16'h0000;
      spurious = 1'b1;
      delay = 0;
      do_reset();
      repeat (4) step();
      n_cmp++; if (pc !== 12'h002 || n !== 1'b1) begin n_fail++; $display("FAIL jge_not_taken: pc=%h n=%b, required 002 1", pc, n); end
      repeat (4) step();
      n_cmp++; if (pc !== 12'h020) begin n_fail++; $display("FAIL jne_taken: pc=%h, required 020", pc); end
      repeat (4) step();
      n_cmp++; if (pc !== 12'h022 || z !== 1'b1) begin n_fail++; $display("FAIL jne_not_taken: pc=%h z=%b, required 022 1", pc, z); end
      repeat (2) step();
      n_cmp++; if (pc !== 12'hFFF || bus.Rd !== 1'b1 || bus.Address !== 12'hFFF) begin n_fail++; $display("FAIL jmp_fetch: pc=%h rd=%b addr=%h, required FFF 1 FFF", pc, bus.Rd, bus.Address); end
      repeat (2) step();
      n_cmp++; if (pc !== 12'h000 || halted !== 1'b1) begin n_fail++; $display("FAIL pc_wrap: pc=%h halted=%b, required 000 1", pc, halted); end
      spurious = 1'b0;
   endtask

   task automatic test_illegal();
      clear_mem();
      mem[0] = 16'h9000;
      delay = 0;
      do_reset();
      repeat (2) step();
      n_cmp++; if (illegal !== 1'b1 || halted !== 1'b1 || f !== 4'h9) begin n_fail++; $display("FAIL illegal_set: illegal=%b halted=%b f=%h, required 1 1 9", illegal, halted, f); end
      spurious = 1'b1;
      repeat (3) begin
         step();
         n_cmp++; if (bus.Rd !== 1'b0 || bus.Wr !== 1'b0 || illegal !== 1'b1 || pc !== 12'h001) begin n_fail++; $display("FAIL illegal_hold: rd=%b wr=%b illegal=%b pc=%h, required 0 0 1 001", bus.Rd, bus.Wr, illegal, pc); end
      end
      spurious = 1'b0;
   endtask

   task automatic test_reset_mid_sta();
      clear_mem();
      mem[0] = 16'h0005; mem[1] = 16'h1007; mem[5] = 16'h1234;
      delay = 0;
      do_reset();
      repeat (3) step();
      n_cmp++; if (bus.Wr !== 1'b1 || bus.Address !== 12'h007 || bus.Dout !== 16'h1234) begin n_fail++; $display("FAIL sta_request: wr=%b addr=%h dout=%h, required 1 007 1234", bus.Wr, bus.Address, bus.Dout); end
      ack_hold = 1'b1;
      repeat (2) step();
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.Wr !== 1'b0 || bus.Rd !== 1'b0 || acc !== '0 || pc !== '0) begin n_fail++; $display("FAIL async_abort: wr=%b rd=%b acc=%h pc=%h, required 0 0 0 0", bus.Wr, bus.Rd, acc, pc); end
      ack_hold = 1'b0;
      wait_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.Rd !== 1'b1 || bus.Address !== '0 || acc !== '0 || mem[7] !== '0) begin n_fail++; $display("FAIL after_abort: rd=%b addr=%h acc=%h mem7=%h, required 1 0 0 0", bus.Rd, bus.Address, acc, mem[7]); end
   endtask

   task automatic test_narrow();
      logic [7:0] a, b, expv;
      bit         sub;
      for (int i = 0; i < 16; i++) mem8[i] = 8'h00;
      mem8[0] = 8'h08; mem8[1] = 8'h29; mem8[2] = 8'h3A; mem8[3] = 8'h70;
      mem8[8] = 8'h7F; mem8[9] = 8'h01; mem8[10] = 8'h80;
      do_reset();
      repeat (4) step8();
      n_cmp++; if (acc8 !== 8'h80 || n8 !== 1'b1) begin n_fail++; $display("FAIL narrow_add: acc=%h n=%b, required 80 1", acc8, n8); end
      repeat (2) step8();
      n_cmp++; if (acc8 !== 8'h00 || z8 !== 1'b1) begin n_fail++; $display("FAIL narrow_sub: acc=%h z=%b, required 00 1", acc8, z8); end
      repeat (2) step8();
      n_cmp++; if (halted8 !== 1'b1 || pc8 !== 4'h4) begin n_fail++; $display("FAIL narrow_halt: halted=%b pc=%h, required 1 4", halted8, pc8); end
      for (int t = 0; t < 4; t++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         sub = 1'($urandom_range(0, 1));
         expv = sub ? a - b : a + b;
         mem8[0] = 8'h08; mem8[1] = sub ? 8'h39 : 8'h29; mem8[2] = 8'h70;
         mem8[8] = a; mem8[9] = b;
         do_reset();
         repeat (6) step8();
         n_cmp++; if (acc8 !== expv || n8 !== expv[7] || z8 !== (expv == 8'h00) || halted8 !== 1'b1) begin n_fail++; $display("FAIL narrow_rand: a=%h b=%h sub=%b acc=%h n=%b z=%b halted=%b, required acc %h", a, b, sub, acc8, n8, z8, halted8, expv); end
      end
   endtask

   task automatic test_random_programs();
      logic [3:0] op;
      int         opnd;
      for (int p = 0; p < 6; p++) begin
         clear_mem();
         for (int a = 0; a < 16; a++) begin
            op   = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 6));
            opnd = (op >= 4'd4 && op <= 4'd6) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 31));
            mem[a] = {op, AW'(opnd)};
         end
         mem[$urandom_range(8, 15)] = 16'h7000;
         for (int a = 16; a < 32; a++) begin
            case ($urandom_range(0, 3))
               0:       mem[a] = 16'h0000;
               1:       mem[a] = 16'h8000;
               default: mem[a] = DW'($urandom);
            endcase
         end
         spurious = 1'b1;
         execute_and_check(int'($urandom_range(0, 3)), 30, $sformatf("random%0d", p));
      end
      spurious = 1'b0;
   endtask

   initial begin
      bus.Ack  = 1'b0;
      bus.Din  = '0;
      bus8.Ack = 1'b0;
      bus8.Din = '0;
      test_reset();
      test_basic();
      test_wait_states();
      test_jumps();
      test_illegal();
      test_reset_mid_sta();
      test_narrow();
      test_random_programs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mu0_core_param.md
MU0_CORE_PARAM -- requirements
Module: mu0_core_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data/accumulator/instruction width; legal range 8..32.
REQ-002 SHALL have parameter ADDR_W, default 12, address and PC width; legal range 4..DATA_W-4.
REQ-003 SHALL have port Clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Din, input, DATA_W, memory read data, valid when Ack=1.
REQ-006 SHALL have port Ack, input, 1, memory completion; meaningful only while Rd or Wr=1.
REQ-007 SHALL have port Address, output, ADDR_W, memory address.
REQ-008 SHALL have port Dout, output, DATA_W, write data; equals Acc.
REQ-009 SHALL have port Rd, output, 1, read request.
REQ-010 SHALL have port Wr, output, 1, write request.
REQ-011 SHALL have port F, output, 4, IR[DATA_W-1:DATA_W-4] (opcode).
REQ-012 SHALL have port PC, output, ADDR_W, program counter.
REQ-013 SHALL have port Acc, output, DATA_W, accumulator.
REQ-014 SHALL have port N, output, 1, Acc[DATA_W-1], combinational.
REQ-015 SHALL have port Z, output, 1, 1 when Acc==0, combinational.
REQ-016 SHALL have port Halted, output, 1, 1 in HALT state.
REQ-017 SHALL have port Illegal, output, 1, sticky; set when opcode 8..15 is executed.

Function
REQ-018 SHALL implement an FSM with states FETCH, EXEC, HALT; the operand field S=IR[ADDR_W-1:0].
REQ-019 FETCH: Rd=1, Address=PC; Rd is held with Address stable until Ack=1; on Ack, IR<=Din, PC<=PC+1 mod 2^ADDR_W, next EXEC.
REQ-020 EXEC, LDA (0)/ADD (2)/SUB (3): Rd=1, Address=S, held until Ack; on Ack, Acc<=Din / Acc+Din / Acc-Din mod 2^DATA_W, next FETCH.
REQ-021 EXEC, STA (1): Wr=1, Address=S, Dout=Acc, held until Ack; on Ack, next FETCH with Acc unchanged.
REQ-022 EXEC, JMP (4): PC<=S, next FETCH, one cycle, no memory access.
REQ-023 EXEC, JGE (5): PC<=S when N=0, else PC unchanged; next FETCH, one cycle.
REQ-024 EXEC, JNE (6): PC<=S when Z=0, else PC unchanged; next FETCH, one cycle.
REQ-025 EXEC, STP (7): next HALT, one cycle; PC remains pointing past the STP.
REQ-026 EXEC, opcodes 8..15: Illegal<=1, next HALT.
REQ-027 HALT: Rd=Wr=0; all registers hold; the state is left only by Reset.
REQ-028 Rd and Wr SHALL never both be 1; Ack while Rd=Wr=0 SHALL be ignored.
REQ-029 Ack in the same cycle a request first asserts SHALL complete it (zero-wait memory gives 2-cycle LDA/ADD/SUB/STA and 2-cycle JMP/JGE/JNE including fetch).
REQ-030 Address SHALL equal PC when not in EXEC with a memory opcode, else S.
REQ-031 Carry/overflow SHALL be discarded; N and Z SHALL reflect the registered Acc, not the ALU result.

Reset
REQ-032 Reset=1 SHALL immediately, without a clock, force state FETCH, PC=0, Acc=0, IR=0, Illegal=0, Rd=0, Wr=0, Halted=0.
REQ-033 Reset asserted mid-handshake SHALL abort the access; the first request after release SHALL be a fetch from address 0.
REQ-034 On the first rising edge after Reset falls, FSM SHALL be in FETCH with Rd=1, Address=0.

Verification
REQ-035 Defaults, zero-wait memory mem[0]=0x0005 (LDA 5), mem[1]=0x2006 (ADD 6), mem[2]=0x1007 (STA 7), mem[3]=0x7000, mem[5]=0x0003, mem[6]=0xFFFF -> mem[7]=0x0002, Acc=0x0002, Halted=1, PC=4.
REQ-036 Jumps: Acc=0x8000 (N=1), JGE 0x020 -> PC unchanged; Acc=0x0001, JNE 0x020 -> PC=0x020; Acc=0, JNE -> PC unchanged; JMP 0xFFF -> next fetch at 0xFFF, then PC wraps to 0x000.
REQ-037 Wait states: Ack delayed 3 cycles on every access -> Rd/Wr and Address held stable 4 cycles per access; results identical to REQ-035.
REQ-038 Illegal: mem[0]=0x9000 -> Illegal=1, Halted=1 after 2 cycles; Rd=Wr=0 thereafter.
REQ-039 Reset mid-STA with Wr=1 and no Ack -> Wr drops asynchronously; after release the first access is Rd at address 0 with Acc=0.
REQ-040 DATA_W=8, ADDR_W=4: Acc=0x7F, ADD of 0x01 -> Acc=0x80, N=1; then SUB of 0x80 -> Acc=0x00, Z=1.
